// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache miss path: responder FSM encoding,
// default backing-store fill value and a constant-safe ceil(log2) helper.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

    localparam logic [10:0] DEFAULT_FILL_VALUE = 11'h3F3;

    // Smallest n with 2**n >= value; usable in parameter expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_storage_array.sv
// Single-port word array with synchronous write and combinational read;
// every word returns to FILL_VALUE on reset.
module mem_storage_array
    import cache_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 11,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(DEFAULT_FILL_VALUE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // NOTE: the array is reset on purpose: the cache relies on a known fill
    // value after reset, so this maps to flops rather than an SRAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= FILL_VALUE;
            end
        end else if (wr_en) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/main_memory_responder.sv
// Backing-store responder: one outstanding single-word read/write request,
// fixed programmable latency, response held until accepted, saturating stats.
module main_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    DATA_WIDTH = 11,
    parameter int                    LATENCY    = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_VALUE = DATA_WIDTH'(DEFAULT_FILL_VALUE),
    parameter int                    STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] read_count,
    output logic [STAT_WIDTH-1:0] write_count
);

    localparam int CNT_WIDTH = clog2(LATENCY + 1);

    mem_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  accept;
    logic                  finish;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // NOTE: non-blocking assignments on every register so all flops update
    // from the same pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    finish     = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            cnt         <= '0;
            resp_data   <= '0;
            read_count  <= '0;
            write_count <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                write_q <= req_write;
                wdata_q <= req_wdata;
                cnt     <= CNT_WIDTH'(LATENCY - 1);
            end else if (state == ST_WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // The write lands in the array on this same edge, so the echo
            // comes from the latched data rather than the pre-write read.
            if (finish) begin
                resp_data <= write_q ? wdata_q : mem_rdata;
                if (write_q) begin
                    if (write_count != '1) write_count <= write_count + STAT_WIDTH'(1);
                end else begin
                    if (read_count != '1) read_count <= read_count + STAT_WIDTH'(1);
                end
            end
        end
    end

    mem_storage_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .FILL_VALUE (FILL_VALUE)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .wr_en (finish & write_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

endmodule
